nibble_serial_subtractor: RTL and testbench

- Multi-cycle 16-bit subtractor computing diff = a - b - bin.
- Processes one 4-bit slice per clock through a single carry-lookahead slice; the carry/borrow is kept in a register between slices.
- Counterpart to the combinational rippled-CLA adder datapath: same operand width, subtract direction, traded area for latency.
- Sits between a valid/ready operand source and a valid/ready result sink.

---
 rtl/nibble_serial_subtractor_pkg.sv | 17 +
 rtl/cla_slice_4bit.sv | 31 +++
 rtl/nibble_serial_subtractor.sv | 130 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Slice-counter width for a given slice count.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice_4bit.sv
// Combinational 4-bit carry-lookahead slice: s = x + y + ci.
module cla_slice_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one 4-bit CLA slice per clock.
// Define ADDSUB_OP_EN to add an op port selecting a + b + bin.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = nibble_serial_subtractor_pkg::SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef ADDSUB_OP_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE_W;
  localparam int CW  = cnt_w(NSL);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             bout_q;
  logic             ovf_q;
  logic             op_in;
  logic             add_op;
  logic             last;
  logic [3:0]       s;
  logic             co;

`ifdef ADDSUB_OP_EN
  logic op_q;
  assign op_in  = op;
  assign add_op = op_q;
`else
  assign op_in  = 1'b0;
  assign add_op = 1'b0;
`endif

  cla_slice_4bit u_slice (
    .x  (a_sh[3:0]),
    .y  (b_sh[3:0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last      = (cnt == CW'(NSL - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = BUSY;
      BUSY: if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operands shift right one slice per cycle; sums enter diff from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef ADDSUB_OP_EN
      op_q   <= 1'b0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        cnt   <= '0;
        a_sh  <= a;
        b_sh  <= op_in ? b : ~b;
        carry <= op_in ? bin : ~bin;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`ifdef ADDSUB_OP_EN
        op_q  <= op;
`endif
      end else if (state == BUSY) begin
        cnt    <= cnt + 1'b1;
        a_sh   <= a_sh >> SLICE_W;
        b_sh   <= b_sh >> SLICE_W;
        diff_q <= {s, diff_q[WIDTH-1:SLICE_W]};
        carry  <= co;
        if (last) begin
          bout_q <= add_op ? co : ~co;
          ovf_q  <= (add_op ? (a_msb == b_msb)
                            : (a_msb != b_msb))
                    && (s[3] != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor.
// Random and directed operands vs an arithmetic reference model.
module tb_nibble_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int   errors;
  int   checks;
  exp_t sb[$];

  nibble_serial_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef ADDSUB_OP_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic ci,
                                 input logic add);
    exp_t r;
    int   ux, uy, sx, sy, ures, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ures = add ? ux + uy + int'(ci) : ux - uy - int'(ci);
    sres = add ? sx + sy + int'(ci) : sx - sy - int'(ci);
    r.d  = ures[15:0];
    r.bo = add ? (ures > 65535) : (ures < 0);
    r.ov = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  // Monitor: the edge after a negedge with valid & ready completes a result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_result", {14'd0, diff, bout, ovf}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({diff, bout, ovf} == e, "result",
              {14'd0, diff, bout, ovf}, {14'd0, e});
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check(1'b0, "in_ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic add, input int hold);
    int   n;
    exp_t cap;
    out_ready = (hold == 0);
    wait_ready();
    a = x; b = y; bin = ci; op = add;
    in_valid = 1'b1;
    sb.push_back(model(x, y, ci, add));
    @(posedge clk); #1;
    // Junk on the inputs while busy must be ignored.
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
    in_valid = 1'b0;
    check(n == 4, "latency", n, 4);
    if (hold > 0) begin
      cap = {diff, bout, ovf};
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({out_valid, in_ready, diff, bout, ovf} == {2'b10, cap},
              "hold_stable", {12'd0, out_valid, in_ready, diff, bout, ovf},
              {12'd0, 2'b10, cap});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check(!out_valid && in_ready, "release",
          {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    bit seen;
    logic [15:0] edges [6];
    edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h8000;
    edges[3] = 16'h7FFF; edges[4] = 16'h0001; edges[5] = 16'hAAAA;
    errors = 0; checks = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0; op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({in_ready, out_valid, diff, bout, ovf} == {2'b10, 18'd0},
          "reset_state", {12'd0, in_ready, out_valid, diff, bout, ovf},
          {12'd0, 2'b10, 18'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0034, 1'b0, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h0005, 16'h0005, 1'b1, 1'b0, 0);
    do_op(16'hAAAA, 16'h0000, 1'b0, 1'b0, 3);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 0);

    // Reset in the second BUSY cycle discards the operation.
    out_ready = 1'b1;
    wait_ready();
    a = 16'h5555; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check({out_valid, in_ready, diff, bout, ovf} == {2'b01, 18'd0},
          "mid_busy_reset", {12'd0, out_valid, in_ready, diff, bout, ovf},
          {12'd0, 2'b01, 18'd0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(!seen, "no_result_after_reset", seen, 0);
    do_op(16'h1000, 16'h0001, 1'b1, 1'b0, 0);

`ifdef ADDSUB_OP_EN
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      logic add;
      x = (i % 4 == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      y = (i % 5 == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
`ifdef ADDSUB_OP_EN
      add = 1'($urandom);
`else
      add = 1'b0;
`endif
      do_op(x, y, 1'($urandom), add, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
